// File: rtl/pic_interrupt_controller.sv
// Interrupt flag/enable block for the PIC16F946 soft core: INTCON<6:0>, PIR1, PIE1,
// pin synchronisers, edge/change detection and the registered IRQ request.
module pic_interrupt_controller #(
  parameter logic [8:0] INTCON_LOW = 9'h00B,
  parameter logic [8:0] PIR1_ADDR  = 9'h00C,
  parameter logic [8:0] PIE1_ADDR  = 9'h08C
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic [8:0] File_Address,
  input  logic [7:0] File_Data_In,
  input  logic       File_Latch,
  input  logic       GIE,
  input  logic       INTEDG,
  input  logic       T0_Overflow,
  input  logic       INT_Pin,
  input  logic [3:0] RB_Pins,
  input  logic       RB_Read,
  input  logic [7:0] Periph_Event,
  output logic [7:0] Read_Data,
  output logic       Read_Hit,
  output logic       IRQ,
  output logic       T0IE
);

  logic [6:0] intcon_q, intcon_d;
  logic [7:0] pir1_q, pir1_d;
  logic [7:0] pie1_q, pie1_d;
  logic       irq_q;
  logic [1:0] int_sync_q;
  logic       int_dly_q;
  logic [3:0] rb_sync1_q, rb_sync2_q, rb_latch_q;

  logic hit_intcon, hit_pir1, hit_pie1;
  logic int_edge, rb_change, pending;

  // INTCON is mirrored in every bank, so only the low seven address bits decode.
  assign hit_intcon = (File_Address[6:0] == INTCON_LOW[6:0]);
  assign hit_pir1   = (File_Address == PIR1_ADDR);
  assign hit_pie1   = (File_Address == PIE1_ADDR);

  // Edge polarity is applied to already-delayed data, so flipping INTEDG alone is silent.
  assign int_edge  = INTEDG ? (int_sync_q[1] & ~int_dly_q) : (~int_sync_q[1] & int_dly_q);
  assign rb_change = (rb_sync2_q != rb_latch_q);

  assign pending = (intcon_q[5] & intcon_q[2]) | (intcon_q[4] & intcon_q[1]) |
                   (intcon_q[3] & intcon_q[0]) | (intcon_q[6] & (|(pie1_q & pir1_q)));

  always_comb begin
    intcon_d = intcon_q;
    pir1_d   = pir1_q;
    pie1_d   = pie1_q;
    if (File_Latch && hit_intcon) intcon_d = File_Data_In[6:0];
    if (File_Latch && hit_pir1)   pir1_d   = File_Data_In;
    if (File_Latch && hit_pie1)   pie1_d   = File_Data_In;
    // Hardware sets are applied after the write so they win bit by bit.
    intcon_d[2] = intcon_d[2] | T0_Overflow;
    intcon_d[1] = intcon_d[1] | int_edge;
    intcon_d[0] = intcon_d[0] | rb_change;
    pir1_d      = pir1_d | Periph_Event;
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      intcon_q   <= '0;
      pir1_q     <= '0;
      pie1_q     <= '0;
      irq_q      <= 1'b0;
      int_sync_q <= '0;
      int_dly_q  <= 1'b0;
      rb_sync1_q <= '0;
      rb_sync2_q <= '0;
      rb_latch_q <= '0;
    end else begin
      intcon_q   <= intcon_d;
      pir1_q     <= pir1_d;
      pie1_q     <= pie1_d;
      irq_q      <= GIE & pending;
      int_sync_q <= {int_sync_q[0], INT_Pin};
      int_dly_q  <= int_sync_q[1];
      rb_sync1_q <= RB_Pins;
      rb_sync2_q <= rb_sync1_q;
      if (RB_Read) rb_latch_q <= rb_sync2_q;
    end
  end

  always_comb begin
    Read_Data = 8'h00;
    Read_Hit  = 1'b1;
    if (hit_intcon)    Read_Data = {GIE, intcon_q};
    else if (hit_pir1) Read_Data = pir1_q;
    else if (hit_pie1) Read_Data = pie1_q;
    else               Read_Hit  = 1'b0;
  end

  assign IRQ  = irq_q;
  assign T0IE = intcon_q[5];

endmodule

// File: tb/tb_pic_interrupt_controller.sv
// Randomised plus directed bench for pic_interrupt_controller against a history-based
// model of flags, pad samples and the IRQ request.
module tb_pic_interrupt_controller;

  logic       Clk = 1'b0;
  logic       nReset;
  logic [8:0] File_Address;
  logic [7:0] File_Data_In;
  logic       File_Latch;
  logic       GIE;
  logic       INTEDG;
  logic       T0_Overflow;
  logic       INT_Pin;
  logic [3:0] RB_Pins;
  logic       RB_Read;
  logic [7:0] Periph_Event;
  logic [7:0] Read_Data;
  logic       Read_Hit;
  logic       IRQ;
  logic       T0IE;

  pic_interrupt_controller dut (
    .Clk          (Clk),
    .nReset       (nReset),
    .File_Address (File_Address),
    .File_Data_In (File_Data_In),
    .File_Latch   (File_Latch),
    .GIE          (GIE),
    .INTEDG       (INTEDG),
    .T0_Overflow  (T0_Overflow),
    .INT_Pin      (INT_Pin),
    .RB_Pins      (RB_Pins),
    .RB_Read      (RB_Read),
    .Periph_Event (Periph_Event),
    .Read_Data    (Read_Data),
    .Read_Hit     (Read_Hit),
    .IRQ          (IRQ),
    .T0IE         (T0IE)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // Model state: flags as plain bytes, pad sample histories, RB reference snapshot.
  logic [6:0] m_intcon;
  logic [7:0] m_pir1, m_pie1;
  logic       m_irq;
  logic [2:0] int_p;     // [0]=last sample, [1]=one before, [2]=two before
  logic [3:0] rb_h [2];  // [0]=last sample, [1]=one before
  logic [3:0] rb_ref;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_intcon = '0; m_pir1 = '0; m_pie1 = '0; m_irq = 1'b0;
    int_p = '0; rb_h[0] = '0; rb_h[1] = '0; rb_ref = '0;
  endtask

  // One posedge worth of behaviour using the inputs present at that edge.
  task automatic model_step();
    logic pend, edge_seen, rb_set;
    logic [3:0] rb_syn;
    pend = (m_intcon[5] && m_intcon[2]) || (m_intcon[4] && m_intcon[1]) ||
           (m_intcon[3] && m_intcon[0]) || (m_intcon[6] && ((m_pie1 & m_pir1) != 0));
    edge_seen = INTEDG ? (int_p[1] && !int_p[2]) : (!int_p[1] && int_p[2]);
    rb_syn = rb_h[1];
    rb_set = (rb_syn != rb_ref);
    if (File_Latch) begin
      if (File_Address[6:0] == 7'h0B) m_intcon = File_Data_In[6:0];
      if (File_Address == 9'h00C) m_pir1 = File_Data_In;
      if (File_Address == 9'h08C) m_pie1 = File_Data_In;
    end
    if (T0_Overflow) m_intcon[2] = 1'b1;
    if (edge_seen)   m_intcon[1] = 1'b1;
    if (rb_set)      m_intcon[0] = 1'b1;
    m_pir1 = m_pir1 | Periph_Event;
    if (RB_Read) rb_ref = rb_syn;
    int_p = {int_p[1:0], INT_Pin};
    rb_h[1] = rb_h[0];
    rb_h[0] = RB_Pins;
    m_irq = GIE && pend;
  endtask

  task automatic check_read();
    logic       hit;
    logic [7:0] exp;
    hit = 1'b1;
    exp = 8'h00;
    if (File_Address[6:0] == 7'h0B) exp = {GIE, m_intcon};
    else if (File_Address == 9'h00C) exp = m_pir1;
    else if (File_Address == 9'h08C) exp = m_pie1;
    else hit = 1'b0;
    chk("read_hit", Read_Hit, hit);
    if (hit) chk("read_data", Read_Data, exp);
  endtask

  // Called just after a negedge; returns at the following negedge.
  task automatic cycle();
    #1;
    check_read();
    @(posedge Clk);
    model_step();
    @(negedge Clk);
    chk("irq", IRQ, m_irq);
    chk("t0ie", T0IE, m_intcon[5]);
  endtask

  task automatic wr(input logic [8:0] a, input logic [7:0] d);
    File_Address = a; File_Data_In = d; File_Latch = 1'b1;
    cycle();
    File_Latch = 1'b0;
  endtask

  task automatic rd_lit(input string name, input logic [8:0] a, input logic [7:0] exp);
    File_Address = a;
    #1;
    chk(name, Read_Data, exp);
  endtask

  // Asynchronous reset between edges; the outputs must clear before the next posedge.
  task automatic mid_reset(input bit literal);
    #2;
    nReset = 1'b0;
    GIE = 1'b0;
    model_reset();
    #1;
    chk("rst_irq", IRQ, 1'b0);
    if (literal) begin
      rd_lit("rst_intcon", 9'h00B, 8'h00);
      rd_lit("rst_pir1", 9'h00C, 8'h00);
      rd_lit("rst_pie1", 9'h08C, 8'h00);
    end
    @(negedge Clk);
    nReset = 1'b1;
  endtask

  initial begin
    nReset = 1'b0; File_Address = '0; File_Data_In = '0; File_Latch = 1'b0;
    GIE = 1'b0; INTEDG = 1'b0; T0_Overflow = 1'b0; INT_Pin = 1'b0; RB_Pins = '0;
    RB_Read = 1'b0; Periph_Event = '0;
    model_reset();
    #1;
    rd_lit("reset_intcon", 9'h00B, 8'h00);
    rd_lit("reset_pir1", 9'h00C, 8'h00);
    chk("reset_irq", IRQ, 1'b0);
    @(negedge Clk);
    @(negedge Clk);
    nReset = 1'b1;
    repeat (3) cycle();

    // Timer0 overflow raises T0IF at once and IRQ one Clk later.
    GIE = 1'b1;
    wr(9'h00B, 8'h20);
    T0_Overflow = 1'b1;
    cycle();
    T0_Overflow = 1'b0;
    rd_lit("t1_intcon", 9'h00B, 8'hA4);
    chk("t1_irq_n", IRQ, 1'b0);
    cycle();
    chk("t1_irq_n1", IRQ, 1'b1);
    GIE = 1'b0;
    wr(9'h00B, 8'h00);
    cycle();

    // Falling INT edge sets INTF on the third posedge; a rising one does not.
    INT_Pin = 1'b1;
    repeat (4) cycle();
    wr(9'h00B, 8'h10);
    rd_lit("t2_rise", 9'h00B, 8'h10);
    INT_Pin = 1'b0;
    cycle();
    rd_lit("t2_e1", 9'h00B, 8'h10);
    cycle();
    rd_lit("t2_e2", 9'h00B, 8'h10);
    cycle();
    rd_lit("t2_e3", 9'h00B, 8'h12);

    // Write collides with the overflow: set wins on T0IF, T0IE takes the write.
    GIE = 1'b1;
    wr(9'h00B, 8'h20);
    T0_Overflow = 1'b1;
    wr(9'h00B, 8'h00);
    T0_Overflow = 1'b0;
    rd_lit("t3_intcon", 9'h00B, 8'h84);
    chk("t3_irq", IRQ, 1'b0);
    cycle();
    chk("t3_irq2", IRQ, 1'b0);
    GIE = 1'b0;
    wr(9'h00B, 8'h00);

    // RB change: clear is overridden until the mismatch latch is reloaded.
    RB_Pins = 4'hA;
    wr(9'h00B, 8'h08);
    cycle();
    cycle();
    rd_lit("t4_set", 9'h00B, 8'h09);
    wr(9'h00B, 8'h08);
    rd_lit("t4_swclr", 9'h00B, 8'h09);
    cycle();
    rd_lit("t4_again", 9'h00B, 8'h09);
    RB_Read = 1'b1;
    cycle();
    RB_Read = 1'b0;
    wr(9'h00B, 8'h08);
    rd_lit("t4_clr", 9'h00B, 8'h08);
    cycle();
    rd_lit("t4_stay", 9'h00B, 8'h08);

    // Peripheral path through PEIE and PIE1.
    wr(9'h08C, 8'h01);
    wr(9'h00B, 8'h40);
    GIE = 1'b1;
    Periph_Event = 8'h01;
    cycle();
    Periph_Event = 8'h00;
    rd_lit("t5_pir1", 9'h00C, 8'h01);
    cycle();
    chk("t5_irq", IRQ, 1'b1);
    GIE = 1'b0;
    cycle();
    chk("t5_irq_off", IRQ, 1'b0);
    GIE = 1'b1;
    cycle();
    chk("t6_pre_irq", IRQ, 1'b1);
    mid_reset(1'b1);
    repeat (3) cycle();

    // Randomised traffic checked every cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 7))
        0: File_Address = 9'h00B;
        1: File_Address = 9'h08B;
        2: File_Address = 9'h10B;
        3: File_Address = 9'h18B;
        4: File_Address = 9'h00C;
        5: File_Address = 9'h08C;
        default: File_Address = 9'($urandom);
      endcase
      File_Data_In = 8'($urandom);
      File_Latch   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) GIE = ~GIE;
      if ($urandom_range(0, 49) == 0) INTEDG = ~INTEDG;
      T0_Overflow  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) INT_Pin = ~INT_Pin;
      if ($urandom_range(0, 9) == 0) RB_Pins = 4'($urandom);
      RB_Read      = ($urandom_range(0, 7) == 0);
      Periph_Event = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      if ($urandom_range(0, 399) == 0) mid_reset(1'b0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
